pipeline_if_skid: RTL
=====================

// Module: pipeline_if_skid
// PURPOSE
//  Parametrised IF/ID pipeline register: the successor to the fixed 8/16-bit latch.
//  Sits between fetch and decode. Adds a valid/ready handshake, a 2-entry skid buffer
//  (full throughput, no combinational ready path), flush-to-NOP, and a stall counter.
//  Decodes ra/rb/ea fields from the instruction at register time.
// PARAMETERS
//  PC_W        8      width of PC+2 value carried with instruction
//  INST_W      16     instruction width
//  REG_W       2      width of ra/rb register specifiers
//  RA_LSB      10     LSB position of ra field in instruction
//  RB_LSB      8      LSB position of rb field in instruction
//  EA_W        8      width of ea field, taken from inst[EA_W-1:0]
//  NOP_INST    0      instruction word loaded on reset/flush (INST_W bits)
//  STALL_CNT_W 16     width of saturating stall counter
// PORTS
//  clk        in   1            clock, all logic posedge
//  rst        in   1            synchronous active-high reset
//  flush      in   1            discard all held beats, load NOP
//  in_valid   in   1            fetch beat valid
//  in_ready   out  1            buffer can accept a beat
//  pc2_in     in   PC_W         PC+2 of fetched instruction
//  inst_in    in   INST_W       fetched instruction
//  out_valid  out  1            decode-side beat valid
//  out_ready  in   1            decode accepts beat
//  pc2_out    out  PC_W         registered PC+2
//  inst_out   out  INST_W       registered instruction
//  ra         out  REG_W        inst[RA_LSB+REG_W-1:RA_LSB]
//  rb         out  REG_W        inst[RB_LSB+REG_W-1:RB_LSB]
//  ea         out  EA_W         inst[EA_W-1:0]
//  stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Clocking: one clock clk; reset rst is synchronous, active-high.
//  Reset: out_valid=0, skid empty, in_ready=1 next cycle, pc2_out=0, inst_out=NOP_INST,
//   ra/rb/ea = fields of NOP_INST, stall_cnt=0. Priority: rst > flush > normal.
//  State: main reg (drives outputs, valid=out_valid) + skid reg (skid_v). in_ready = !skid_v,
//   a pure register output; no combinational path out_ready->in_ready.
//  acc = in_valid&in_ready; drn = out_valid&out_ready.
//  If drn or !out_valid: skid_v -> main<=skid, skid_v<=0; else acc -> main<=in;
//   else out_valid<=0 (payload held, ignored).
//  Else (main held): acc -> skid<=in, skid_v<=1.
//  ra/rb/ea registered together with inst_out from the same source word (in or skid).
//  Latency: accepted beat appears at outputs next cycle when buffer empty. Throughput 1/clk.
//  Ordering strictly FIFO; no beat duplicated or lost except by flush.
//  Flush: out_valid<=0, skid_v<=0, pc2_out<=0, inst_out/ra/rb/ea <= NOP_INST fields.
//   Beat accepted in the flush cycle (handshake completes) is dropped. stall_cnt unchanged.
//  stall_cnt: +1 each cycle out_valid&!out_ready (incl. flush cycle, evaluated pre-flush);
//   saturates at all-ones; cleared only by rst.
//  Field positions must fit INST_W (RA_LSB+REG_W<=INST_W etc.); violation is a config error.
// TESTING
//  1 rst, then in_valid=1 pc2=0x02 inst=0x1A05, out_ready=1 -> next clk out_valid=1,
//    inst_out=0x1A05, ra=2, rb=2, ea=0x05, pc2_out=0x02.
//  2 stream 4 beats back-to-back, out_ready=1 -> 4 consecutive out_valid cycles, in order,
//    in_ready stays 1, stall_cnt=0.
//  3 out_ready=0 while sending A,B,C -> A in main, B in skid, in_ready=0, C not accepted;
//    raise out_ready -> A, B, then C in order; stall_cnt counts held cycles exactly.
//  4 buffer full (A main, B skid), assert flush -> next clk out_valid=0, in_ready=1,
//    inst_out=NOP_INST, pc2_out=0; A, B never appear.
//  5 hold out_ready=0, out_valid=1 for 2^STALL_CNT_W+5 cycles (STALL_CNT_W=4 build) ->
//    stall_cnt sticks at 0xF.
//  6 rst asserted mid-stream with full buffer -> outputs return to reset values next clk,
//    stall_cnt=0; first beat after release passes with 1-cycle latency.

Source files
------------

// File: rtl/pipeline_if_skid.sv
// ----------------------------------------------------------------------------
// pipeline_if_skid
//   IF/ID pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer (main register + one skid register). Full throughput, and
//   in_ready is a pure register output, so there is no combinational path
//   from out_ready to in_ready. Supports flush-to-NOP and a saturating stall
//   counter. The ra/rb/ea fields are decoded when the word is registered.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   flush      in   discard all held beats, load NOP
//   in_valid   in   fetch beat valid
//   in_ready   out  buffer can accept a beat (skid register empty)
//   pc2_in     in   PC+2 of fetched instruction
//   inst_in    in   fetched instruction
//   out_valid  out  decode-side beat valid
//   out_ready  in   decode accepts beat
//   pc2_out    out  registered PC+2
//   inst_out   out  registered instruction
//   ra, rb     out  register specifier fields of inst_out
//   ea         out  inst_out[EA_W-1:0]
//   stall_cnt  out  saturating count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------
module pipeline_if_skid #(
    parameter int unsigned            PC_W        = 8,
    parameter int unsigned            INST_W      = 16,
    parameter int unsigned            REG_W       = 2,
    parameter int unsigned            RA_LSB      = 10,
    parameter int unsigned            RB_LSB      = 8,
    parameter int unsigned            EA_W        = 8,
    parameter logic [INST_W-1:0]      NOP_INST    = '0,
    parameter int unsigned            STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc2_in,
    input  logic [INST_W-1:0]      inst_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc2_out,
    output logic [INST_W-1:0]      inst_out,
    output logic [REG_W-1:0]       ra,
    output logic [REG_W-1:0]       rb,
    output logic [EA_W-1:0]        ea,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Field positions must lie inside the instruction word.
    if ((RA_LSB + REG_W > INST_W) || (RB_LSB + REG_W > INST_W) || (EA_W > INST_W))
    begin : g_cfg_err
        $error("pipeline_if_skid: field positions exceed INST_W");
    end

    localparam logic [REG_W-1:0]       NOP_RA  = NOP_INST[RA_LSB +: REG_W];
    localparam logic [REG_W-1:0]       NOP_RB  = NOP_INST[RB_LSB +: REG_W];
    localparam logic [EA_W-1:0]        NOP_EA  = NOP_INST[EA_W-1:0];
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    logic                  skid_v;
    logic [PC_W-1:0]       skid_pc2;
    logic [INST_W-1:0]     skid_inst;

    logic                  acc;
    logic                  drn;
    logic                  main_free;
    logic [PC_W-1:0]       src_pc2;
    logic [INST_W-1:0]     src_inst;

    assign in_ready = ~skid_v;

    always_comb begin
        acc       = in_valid & ~skid_v;
        drn       = out_valid & out_ready;
        main_free = drn | ~out_valid;
        // A waiting skid beat is older than anything on the input, so it
        // always refills the main register first.
        src_pc2   = skid_v ? skid_pc2  : pc2_in;
        src_inst  = skid_v ? skid_inst : inst_in;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            skid_v    <= 1'b0;
            pc2_out   <= '0;
            inst_out  <= NOP_INST;
            ra        <= NOP_RA;
            rb        <= NOP_RB;
            ea        <= NOP_EA;
        end else if (main_free) begin
            out_valid <= skid_v | acc;
            skid_v    <= 1'b0;
            if (skid_v || acc) begin
                pc2_out  <= src_pc2;
                inst_out <= src_inst;
                ra       <= src_inst[RA_LSB +: REG_W];
                rb       <= src_inst[RB_LSB +: REG_W];
                ea       <= src_inst[EA_W-1:0];
            end
        end else if (acc) begin
            skid_v <= 1'b1;
        end
    end

    // Skid payload needs no reset: it is only read while skid_v is set.
    always_ff @(posedge clk) begin
        if (!main_free && acc) begin
            skid_pc2  <= pc2_in;
            skid_inst <= inst_in;
        end
    end

    // Counts on the pre-flush view of out_valid; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
